// File: rtl/uart_tx_framer.sv
// uart_tx_framer: sequences one UART frame per accepted word onto the serial pin.
// A frame is a start bit, DATA_WIDTH data bits sent LSB first, an optional
// even/odd parity bit, and one or two stop bits. One CLK cycle is one bit period.
//
// Ports:
//   CLK        in   TX bit clock, one cycle per serial bit
//   RST        in   asynchronous active-high reset
//   P_DATA     in   parallel word, sampled on acceptance
//   DATA_VALID in   request to send P_DATA
//   PAR_EN     in   1 = insert parity bit after the data bits
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   STOP2      in   0 = one stop bit, 1 = two stop bits
//   TX_OUT     out  registered serial line, idles high
//   BUSY       out  registered, high from start bit through final stop bit
//   FRAME_DONE out  registered, high during the final stop bit of each frame
module uart_tx_framer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  FRAME_DONE
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    stop2_q, stop2_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    final_stop;
    logic                    accept;

    // The state register always describes the bit currently on the line.
    assign final_stop = (state_q == S_STOP) && (stop_cnt_q == stop2_q);
    assign accept     = DATA_VALID && ((state_q == S_IDLE) || final_stop);

    // State and shadow registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state sequencing; outputs are decoded from the next state so the
    // registered line value lines up with the bit the state describes.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d   = S_DATA;
                bit_cnt_d = '0;
            end
            S_DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d    = par_en_q ? S_PARITY : S_STOP;
                    stop_cnt_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                state_d    = S_STOP;
                stop_cnt_d = 1'b0;
            end
            S_STOP: begin
                if (final_stop) begin
                    state_d = accept ? S_START : S_IDLE;
                end else begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shadow copies make mid-frame input changes invisible to the frame.
        if (accept) begin
            data_d     = P_DATA;
            par_en_d   = PAR_EN;
            par_typ_d  = PAR_TYP;
            stop2_d    = STOP2;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[bit_cnt_d];
            S_PARITY: tx_d = (^data_d) ^ par_typ_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (stop_cnt_d == stop2_d);
    end

    assign TX_OUT     = tx_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;

endmodule
